multicycle_fsm: RTL
===================

// Module: multicycle_fsm
// PURPOSE
//  Main sequencing FSM for the multi-cycle RV32I core. Per instruction it steps the shared
//  ALU, register file, PC and unified memory through fetch/decode/execute/mem/writeback,
//  and stretches memory states on mem_ready. ALU function is decoded externally from alu_op.
// PARAMETERS
//  MAX_WAIT  15  consecutive stall cycles allowed per memory access; 0 disables timeout
//  WAIT_W     4  width of the stall counter; must satisfy 2**WAIT_W > MAX_WAIT
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  op          in   7  instr[6:0] from IR
//  funct3      in   3  instr[14:12] from IR
//  zero,lt,ltu in   1  ALU flags for rs1 op rs2 in the BRANCH state (eq / signed< / unsigned<)
//  mem_ready   in   1  memory has completed the current read or write this cycle
//  pc_write    out  1  load PC from the result bus
//  adr_src     out  1  memory address select: 0=PC, 1=ALUOut
//  mem_read    out  1  memory read request
//  mem_write   out  1  memory write request
//  ir_write    out  1  load IR and OldPC
//  result_src  out  2  00=ALUOut 01=mem data 10=ALU result
//  alu_src_a   out  2  00=PC 01=OldPC 10=rs1 11=zero
//  alu_src_b   out  2  00=rs2 01=imm 10=const 4
//  alu_op      out  2  00=add 01=sub/compare 10=funct-decoded
//  imm_src     out  3  I=000 S=001 B=010 J=011 U=100 (other=000), combinational from op
//  reg_write   out  1  write the result bus to rd
//  illegal_op  out  1  sticky: unsupported op or funct3
//  bus_timeout out  1  sticky: mem_ready watchdog expired
//  state_o     out  5  current state, debug only
// BEHAVIOUR
//  - Reset: state=RST. Every output is 0, except imm_src (a function of op). The stall counter is 0.
//    Reset asserted in any state returns to RST immediately.
//  - RST always moves to FETCH on the next clock.
//  - Outputs are combinational from state plus mem_ready/flags. Signals not listed for a state are 0.
//  - FETCH: mem_read=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
//    ir_write and pc_write are asserted only in the cycle with mem_ready=1, then the FSM goes to DECODE.
//  - DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by op:
//    0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//    1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->AUIPC, else->ILLEGAL.
//  - MEMADR: a=10, b=01, alu_op=00. Next is MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
//  - MEMREAD: mem_read=1, adr_src=1. Holds until mem_ready, then MEMWB.
//  - MEMWB: result_src=01, reg_write=1, then FETCH.
//  - MEMWRITE: mem_write=1, adr_src=1. Both held stable until mem_ready, then FETCH.
//  - EXECR: a=10, b=00, alu_op=10. EXECI: a=10, b=01, alu_op=10. Both go to ALUWB.
//  - ALUWB: result_src=00, reg_write=1, then FETCH.
//  - BRANCH: a=10, b=00, alu_op=01, result_src=00. pc_write=taken, then FETCH.
//    funct3 000:zero  001:!zero  100:lt  101:!lt  110:ltu  111:!ltu.
//    funct3 010/011 goes to ILLEGAL with pc_write=0.
//  - JAL: a=01, b=10, result_src=00, pc_write=1, then ALUWB (writes OldPC+4).
//  - JALR: a=10, b=01, then JALR2. JALR2: a=01, b=10, result_src=00, pc_write=1, then ALUWB.
//  - LUI: a=11, b=01. AUIPC: a=01, b=01. Both use alu_op=00 and go to ALUWB.
//  - ILLEGAL: illegal_op=1, all strobes 0. TIMEOUT: bus_timeout=1, all strobes 0.
//    Both are terminal until rst_n. The flags stay set while in these states.
//  - Watchdog: the counter clears on entry to FETCH/MEMREAD/MEMWRITE and increments each cycle with mem_ready=0.
//    If MAX_WAIT!=0 and the counter==MAX_WAIT with mem_ready=0, the next state is TIMEOUT.
//    mem_ready=1 in that same cycle wins and the FSM proceeds normally.
//  - CPI with mem_ready tied high: R/I/LUI/AUIPC/JAL 4, lw 5, sw 4, branch 3, jalr 5.
// TESTING
//  - Reset release, mem_ready=1, add (op 0110011): RST,FETCH,DECODE,EXECR,ALUWB -> reg_write=1 only in ALUWB.
//  - lw with mem_ready low 3 cycles in MEMREAD: mem_read/adr_src=1 held 4 cycles -> MEMWB reg_write=1, result_src=01.
//  - bne (funct3=001): zero=1 -> pc_write=0; zero=0 -> pc_write=1. Both return to FETCH.
//  - jalr: JALR,JALR2 (pc_write=1, result_src=00),ALUWB -> exactly one pc_write and one reg_write.
//  - op=0000000 -> ILLEGAL, illegal_op=1 held 20 cycles; rst_n pulse -> RST, all outputs 0.
//  - MAX_WAIT=15, mem_ready=0 in FETCH -> TIMEOUT after 16 cycles. With mem_ready=1 on cycle 16 -> DECODE.

Source files
------------

// File: rtl/multicycle_fsm.sv
// Main sequencing FSM of the multi-cycle RV32I core: drives datapath strobes per state,
// stretches memory states on mem_ready and traps unsupported opcodes or a stalled bus.
module multicycle_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       bus_timeout,
    output logic [4:0] state_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic              TIMEOUT_EN = (MAX_WAIT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [4:0] {
        S_RST      = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_MEMADR   = 5'd3,
        S_MEMREAD  = 5'd4,
        S_MEMWB    = 5'd5,
        S_MEMWRITE = 5'd6,
        S_EXECR    = 5'd7,
        S_EXECI    = 5'd8,
        S_ALUWB    = 5'd9,
        S_BRANCH   = 5'd10,
        S_JAL      = 5'd11,
        S_JALR     = 5'd12,
        S_JALR2    = 5'd13,
        S_LUI      = 5'd14,
        S_AUIPC    = 5'd15,
        S_ILLEGAL  = 5'd16,
        S_TIMEOUT  = 5'd17
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              in_mem_state;
    logic              wait_expired;
    logic              branch_taken;
    logic              branch_f3_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign in_mem_state  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // A ready in the limit cycle still completes the access.
    assign wait_expired  = TIMEOUT_EN && !mem_ready && (wait_q == WAIT_LIMIT);
    assign branch_f3_bad = (funct3[2:1] == 2'b01);

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = !ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)         state_d = S_DECODE;
                else if (wait_expired) state_d = S_TIMEOUT;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)         state_d = S_MEMWB;
                else if (wait_expired) state_d = S_TIMEOUT;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)         state_d = S_FETCH;
                else if (wait_expired) state_d = S_TIMEOUT;
            end
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = branch_f3_bad ? S_ILLEGAL : S_FETCH;
            S_JAL:    state_d = S_ALUWB;
            S_JALR:   state_d = S_JALR2;
            S_JALR2:  state_d = S_ALUWB;
            S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_ILLEGAL: state_d = S_ILLEGAL;
            S_TIMEOUT: state_d = S_TIMEOUT;
            default:   state_d = S_RST;
        endcase
    end

    // Stall counter restarts on every state change, so each memory access gets a fresh budget.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_mem_state && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        bus_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = branch_taken && !branch_f3_bad;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_JALR2: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_ILLEGAL: illegal_op  = 1'b1;
            S_TIMEOUT: bus_timeout = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:         imm_src = 3'b001;
            OP_BRANCH:        imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    assign state_o = state_q;

endmodule
